// File: rtl/toggle_pkg.sv
// toggle_pkg: shared state encodings, default widths and sync depth for the toggle event receiver
package toggle_pkg;
  typedef enum logic {S_PRIME = 1'b0, S_RUN = 1'b1} state_t;
  localparam int TOGGLE_CNT_W = 8;
  localparam int TOGGLE_PEND_W = 4;
  localparam int TOGGLE_SYNC_STAGES = 2;
endpackage

// File: rtl/toggle_sync2.sv
// toggle_sync2: flop-chain synchronizer (clk, rst sync active-high, d async in, q synchronized out)
module toggle_sync2
  import toggle_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [TOGGLE_SYNC_STAGES-1:0] ff;
  always_ff @(posedge clk)
    if (rst) ff <= '0;
    else ff <= {ff[TOGGLE_SYNC_STAGES-2:0], d};
  assign q = ff[TOGGLE_SYNC_STAGES-1];
endmodule

// File: rtl/toggle_event_rx.sv
// toggle_event_rx: recovers toggle-line flips as pulses, a wrapping total count and a pending queue drained by valid/ready; define TOGGLE_EVENT_RX_SYNC_EN to add a two-flop input synchronizer. Ports: clk, rst, t_in, evt_pulse, evt_valid, evt_ready, evt_count, pend_count, overflow, clr_ovf
module toggle_event_rx
  import toggle_pkg::*;
#(
  parameter int CNT_W = TOGGLE_CNT_W,
  parameter int PEND_W = TOGGLE_PEND_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              t_in,
  output logic              evt_pulse,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [CNT_W-1:0]  evt_count,
  output logic [PEND_W-1:0] pend_count,
  output logic              overflow,
  input  logic              clr_ovf
);
  logic t_s;
`ifdef TOGGLE_EVENT_RX_SYNC_EN
  localparam int PRIME_CYC = TOGGLE_SYNC_STAGES + 1;
  toggle_sync2 u_sync (.clk(clk), .rst(rst), .d(t_in), .q(t_s));
`else
  localparam int PRIME_CYC = 1;
  assign t_s = t_in;
`endif
  state_t state;
  logic t_ref, hit, dec, full, drop;
  logic [1:0] prime_cnt;
  logic [PEND_W-1:0] pend_nxt;
  assign evt_valid = |pend_count;
  always_comb begin
    hit = (state == S_RUN) && (t_s ^ t_ref);
    dec = evt_valid && evt_ready;
    full = &pend_count;
    drop = hit && !dec && full;
    pend_nxt = (hit && !dec && !full) ? pend_count + 1'b1 :
               (dec && !hit) ? pend_count - 1'b1 : pend_count;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= S_PRIME;
      prime_cnt <= '0;
      t_ref <= 1'b0;
      evt_pulse <= 1'b0;
      evt_count <= '0;
      pend_count <= '0;
      overflow <= 1'b0;
    end else begin
      t_ref <= t_s;
      evt_pulse <= hit;
      evt_count <= evt_count + CNT_W'(hit);
      pend_count <= pend_nxt;
      overflow <= drop | (overflow & ~clr_ovf);
      if (state == S_PRIME) begin
        prime_cnt <= prime_cnt + 1'b1;
        if (prime_cnt == 2'(PRIME_CYC - 1)) state <= S_RUN;
      end
    end
endmodule

// File: tb/tb_toggle_event_rx.sv
// tb_toggle_event_rx: directed self-checking bench for toggle_event_rx (default build)
module tb_toggle_event_rx;
  logic clk = 1'b0, rst, t_in, evt_ready, clr_ovf;
  logic evt_pulse, evt_valid, overflow;
  logic [7:0] evt_count;
  logic [3:0] pend_count;
  int compared = 0, mism = 0, pulses;
  always #5 clk = ~clk;
  toggle_event_rx dut (
    .clk(clk), .rst(rst), .t_in(t_in), .evt_pulse(evt_pulse), .evt_valid(evt_valid),
    .evt_ready(evt_ready), .evt_count(evt_count), .pend_count(pend_count),
    .overflow(overflow), .clr_ovf(clr_ovf)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_all(input string tag, input logic p, input logic v, input logic [7:0] c,
                         input logic [3:0] pc, input logic o);
    chk({tag, ".pulse"}, 32'(evt_pulse), 32'(p));
    chk({tag, ".valid"}, 32'(evt_valid), 32'(v));
    chk({tag, ".count"}, 32'(evt_count), 32'(c));
    chk({tag, ".pend"}, 32'(pend_count), 32'(pc));
    chk({tag, ".ovf"}, 32'(overflow), 32'(o));
  endtask
  initial begin
    rst = 1'b1; t_in = 1'b1; evt_ready = 1'b0; clr_ovf = 1'b0;
    step(); step();
    chk_all("reset", 0, 0, 0, 0, 0);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      pulses += int'(evt_pulse);
    end
    chk("prime_pulses", 32'(pulses), 0);
    chk_all("prime_end", 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      t_in = ~t_in;
      step();
      chk("lat_pulse_hi", 32'(evt_pulse), 1);
      step();
      chk("lat_pulse_lo", 32'(evt_pulse), 0);
    end
    chk_all("three_evts", 0, 1, 3, 3, 0);
    evt_ready = 1'b1;
    step(); chk("drain2", 32'(pend_count), 2);
    step(); chk("drain1", 32'(pend_count), 1);
    step(); chk_all("drain0", 0, 0, 3, 0, 0);
    step(); chk_all("no_underflow", 0, 0, 3, 0, 0);
    evt_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      t_in = ~t_in;
      step();
      chk("b2b_pulse", 32'(evt_pulse), 1);
    end
    chk_all("saturate", 1, 1, 19, 15, 1);
    t_in = ~t_in; evt_ready = 1'b1;
    step();
    chk_all("full_inc_dec", 1, 1, 20, 15, 1);
    evt_ready = 1'b0; clr_ovf = 1'b1;
    step();
    chk_all("clr_ovf", 0, 1, 20, 15, 0);
    t_in = ~t_in;
    step();
    chk_all("drop_beats_clr", 1, 1, 21, 15, 1);
    step();
    chk("clr_again", 32'(overflow), 0);
    clr_ovf = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    evt_ready = 1'b1;
    for (int i = 0; i < 260; i++) begin
      t_in = ~t_in;
      step();
    end
    chk_all("wrap", 1, 1, 4, 1, 0);
    evt_ready = 1'b0;
    for (int i = 0; i < 15; i++) begin
      t_in = ~t_in;
      step();
    end
    chk_all("refill", 1, 1, 19, 15, 1);
    evt_ready = 1'b1;
    for (int i = 0; i < 10; i++) step();
    evt_ready = 1'b0;
    chk_all("pend5", 0, 1, 19, 5, 1);
    rst = 1'b1; t_in = ~t_in;
    step();
    chk_all("mid_rst", 0, 0, 0, 0, 0);
    rst = 1'b0; t_in = 1'b1;
    step();
    chk_all("post_rst_prime", 0, 0, 0, 0, 0);
    step();
    chk_all("post_rst_run", 0, 0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end
endmodule
